// File: rtl/load_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// load_store_unit_pkg
// Shared encodings for the load/store unit and the instruction decoder:
//   - mem_size access-width encodings (also produced by the decoder)
//   - LSU controller state encodings
//   - byte-enable constants for word / half-word lanes
//   - is_misaligned(): alignment rule shared by the lane aligner
// -----------------------------------------------------------------------------
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        MEM_WORD     = 2'b00,
        MEM_HALF     = 2'b01,
        MEM_BYTE     = 2'b10,
        MEM_WORD_ALT = 2'b11   // reserved encoding, handled as a word access
    } mem_size_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } lsu_state_t;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    // Bytes can never be misaligned; halves need an even address; words
    // (including the reserved encoding) need a 4-byte aligned address.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] offset);
        logic result;
        case (size)
            MEM_BYTE: result = 1'b0;
            MEM_HALF: result = offset[0];
            default:  result = |offset;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational lane logic for the load/store unit.
//   size     in   access width (mem_size_t encoding)
//   offset   in   addr[1:0] of the access
//   st_data  in   store value from rt
//   rdata    in   raw word returned by the data bus
//   misalign out  access violates the natural alignment of its width
//   be       out  little-endian byte enables for the bus
//   wdata    out  store data replicated across every lane it may land in
//   ld_data  out  selected lane(s) of rdata, zero-extended
// -----------------------------------------------------------------------------
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic        misalign,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    // Split the read word into its four byte lanes.
    logic [7:0] lane [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        misalign = is_misaligned(size, offset);
        be       = BE_WORD;
        wdata    = st_data;
        ld_data  = rdata;
        case (size)
            MEM_HALF: begin
                be      = offset[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata   = {2{st_data[15:0]}};
                ld_data = offset[1] ? {16'h0000, rdata[31:16]}
                                    : {16'h0000, rdata[15:0]};
            end
            MEM_BYTE: begin
                be      = BE_BYTE0 << offset;
                wdata   = {4{st_data[7:0]}};
                ld_data = {24'h000000, lane[offset]};
            end
            default: begin
                be      = BE_WORD;
                wdata   = st_data;
                ld_data = rdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Multi-cycle load/store controller between the decoder/ALU and a req/ack
// data-memory bus. Holds the pipeline until the access completes, returns
// zero-extended load data, and flags misaligned accesses and bus timeouts.
//   clk, rst_n          core clock / asynchronous active-low reset
//   mem_write, mem_read store / load request (both high = store)
//   mem_size, addr      access width and byte address
//   st_data             store value
//   ld_data             zero-extended load result, valid while in DONE
//   stall               holds PC/pipeline while the access is in flight
//   misalign_err        one-cycle pulse: access rejected for alignment
//   bus_err             one-cycle pulse: no ack within TIMEOUT cycles
//   bus_req/we/addr/be/wdata, bus_rdata, bus_ack   data-memory bus
// -----------------------------------------------------------------------------
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_write,
    input  logic              mem_read,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       st_data,
    output logic [31:0]       ld_data,
    output logic              stall,
    output logic              misalign_err,
    output logic              bus_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ack
);

    // The counter value seen in the last permitted wait cycle.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    lsu_state_t  state_reg;
    logic [7:0]  cnt_reg;
    logic [1:0]  size_reg;
    logic [1:0]  off_reg;

    logic        op;
    logic [1:0]  align_size;
    logic [1:0]  align_off;
    logic        align_misalign;
    logic [3:0]  align_be;
    logic [31:0] align_wdata;
    logic [31:0] align_ld;

    assign op = mem_write | mem_read;

    // Stall drops combinationally in DONE/ERR so the core advances on that
    // edge; gating with rst_n releases the core as soon as reset asserts.
    assign stall = rst_n & op & (state_reg != ST_DONE) & (state_reg != ST_ERR);

    // One aligner serves both phases: live inputs decide launch in IDLE,
    // the captured width/offset steer load extraction while waiting.
    assign align_size = (state_reg == ST_IDLE) ? mem_size   : size_reg;
    assign align_off  = (state_reg == ST_IDLE) ? addr[1:0]  : off_reg;

    lsu_lane_align u_align (
        .size     (align_size),
        .offset   (align_off),
        .st_data  (st_data),
        .rdata    (bus_rdata),
        .misalign (align_misalign),
        .be       (align_be),
        .wdata    (align_wdata),
        .ld_data  (align_ld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            size_reg     <= '0;
            off_reg      <= '0;
            ld_data      <= '0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_be       <= '0;
            bus_wdata    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    misalign_err <= 1'b0;
                    bus_err      <= 1'b0;
                    ld_data      <= '0;
                    cnt_reg      <= '0;
                    if (op) begin
                        if (align_misalign) begin
                            misalign_err <= 1'b1;
                            state_reg    <= ST_ERR;
                        end else begin
                            bus_req   <= 1'b1;
                            bus_we    <= mem_write;   // store wins if both set
                            bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            bus_be    <= align_be;
                            bus_wdata <= align_wdata;
                            size_reg  <= mem_size;
                            off_reg   <= addr[1:0];
                            state_reg <= ST_WAIT;
                        end
                    end
                end

                ST_WAIT: begin
                    // bus_req is always high here, so the ack is qualified.
                    // Checking the ack first lets it win over the timeout.
                    if (bus_ack) begin
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_addr  <= '0;
                        bus_be    <= '0;
                        bus_wdata <= '0;
                        ld_data   <= bus_we ? 32'h0 : align_ld;
                        state_reg <= ST_DONE;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_addr  <= '0;
                        bus_be    <= '0;
                        bus_wdata <= '0;
                        bus_err   <= 1'b1;
                        state_reg <= ST_ERR;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end

                ST_DONE: begin
                    ld_data   <= '0;
                    cnt_reg   <= '0;
                    state_reg <= ST_IDLE;
                end

                ST_ERR: begin
                    misalign_err <= 1'b0;
                    bus_err      <= 1'b0;
                    ld_data      <= '0;
                    cnt_reg      <= '0;
                    state_reg    <= ST_IDLE;
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
